// File: rtl/vexec_pkg.sv
// Shared definitions for the vector/scalar execute stage: ALU function codes,
// FSM state encoding and the chunk-count helper.
package vexec_pkg;

  localparam logic [2:0] ALU_ADD   = 3'b000;
  localparam logic [2:0] ALU_SUB   = 3'b001;
  localparam logic [2:0] ALU_AND   = 3'b010;
  localparam logic [2:0] ALU_OR    = 3'b011;
  localparam logic [2:0] ALU_XOR   = 3'b100;
  localparam logic [2:0] ALU_SHL   = 3'b101;
  localparam logic [2:0] ALU_MUL   = 3'b110;
  localparam logic [2:0] ALU_PASSB = 3'b111;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  // Number of cycles a vector op occupies the stage.
  function automatic int calc_k(input int v, input int e, input int p);
    return v / (e * p);
  endfunction

endpackage

// File: rtl/vexec_lane.sv
// One W-bit combinational ALU element. Define VEXEC_SAT_EN for unsigned
// saturating add/sub; otherwise add/sub wrap modulo 2^W.
module vexec_lane
  import vexec_pkg::*;
#(
  parameter int W = 8
) (
  input  logic [2:0]   alu_ctrl,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] y
);

`ifdef VEXEC_SAT_EN
  logic [W:0] sum;
  assign sum = {1'b0, a} + {1'b0, b};
`endif

  always_comb begin
    y = b;
    case (alu_ctrl)
`ifdef VEXEC_SAT_EN
      ALU_ADD: y = sum[W] ? '1 : sum[W-1:0];
      ALU_SUB: y = (a < b) ? '0 : a - b;
`else
      ALU_ADD: y = a + b;
      ALU_SUB: y = a - b;
`endif
      ALU_AND:   y = a & b;
      ALU_OR:    y = a | b;
      ALU_XOR:   y = a ^ b;
      ALU_SHL:   y = a << b[2:0];
      ALU_MUL:   y = a * b;
      ALU_PASSB: y = b;
      default:   y = b;
    endcase
  end

endmodule

// File: rtl/vexec_stage.sv
// Execute stage: 1-cycle scalar ALU, K-cycle chunked vector ALU with stall_E
// back-pressure, E/M boundary registers and branch compare. Honours VEXEC_SAT_EN.
module vexec_stage
  import vexec_pkg::*;
#(
  parameter int V = 128,
  parameter int N = 32,
  parameter int M = 4,
  parameter int L = 3,
  parameter int E = 8,
  parameter int P = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         flush_X,
  input  logic         regw_E,
  input  logic         memw_E,
  input  logic         regmem_E,
  input  logic         ALUope_E,
  input  logic         branch_E,
  input  logic         vect_E,
  input  logic [4:0]   op_code_E,
  input  logic [L-1:0] ALUctrl_E,
  input  logic [M-1:0] regScr_E,
  input  logic [N-1:0] inm_E,
  input  logic [V-1:0] regA_E,
  input  logic [V-1:0] regB_E,
  output logic         stall_E,
  output logic         branch_taken,
  output logic         regw_M,
  output logic         memw_M,
  output logic         regmem_M,
  output logic         vect_M,
  output logic [M-1:0] regScr_M,
  output logic [V-1:0] res_M,
  output logic [V-1:0] store_M,
  output state_t       state_dbg
);

  localparam int K     = calc_k(V, E, P);
  localparam int CW    = E * P;
  localparam int CNT_W = (K > 1) ? $clog2(K) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(K - 1);

  state_t           state, state_next;
  logic [CNT_W-1:0] cnt, cnt_next;
  logic [V-1:0]     partial, partial_next;

  logic             regw_n, memw_n, regmem_n, vect_n;
  logic [M-1:0]     regscr_n;
  logic [V-1:0]     res_n, store_n;

  logic             vec_run, last, bubble_e;
  logic [V-1:0]     vec_b, merged, base;
  logic [N-1:0]     sc_b, sc_y;
  logic [CW-1:0]    a_chunks [K];
  logic [CW-1:0]    b_chunks [K];
  logic [CW-1:0]    chunk_a, chunk_b, chunk_y;

  logic unused_opcode;
  assign unused_opcode = ^op_code_E;

  // Vector immediates are replicated into every element; scalar ones are used as-is.
  assign vec_b = ALUope_E ? {(V/E){inm_E[E-1:0]}} : regB_E;
  assign sc_b  = ALUope_E ? inm_E : regB_E[N-1:0];

  always_comb begin
    for (int k = 0; k < K; k++) begin
      a_chunks[k] = regA_E[k*CW +: CW];
      b_chunks[k] = vec_b[k*CW +: CW];
    end
  end

  assign chunk_a = a_chunks[cnt];
  assign chunk_b = b_chunks[cnt];

  for (genvar p = 0; p < P; p++) begin : g_lane
    vexec_lane #(.W(E)) u_lane (
      .alu_ctrl (ALUctrl_E[2:0]),
      .a        (chunk_a[p*E +: E]),
      .b        (chunk_b[p*E +: E]),
      .y        (chunk_y[p*E +: E])
    );
  end

  vexec_lane #(.W(N)) u_scalar (
    .alu_ctrl (ALUctrl_E[2:0]),
    .a        (regA_E[N-1:0]),
    .b        (sc_b),
    .y        (sc_y)
  );

  // Chunk 0 starts from a clean slate; later chunks accumulate into partial.
  always_comb begin
    base   = (state == BUSY) ? partial : '0;
    merged = base;
    for (int k = 0; k < K; k++) begin
      if (cnt == CNT_W'(k)) merged[k*CW +: CW] = chunk_y;
    end
  end

  assign bubble_e     = ~regw_E & ~memw_E & ~vect_E;
  assign vec_run      = ~rst & ~flush_X & ((state == BUSY) | vect_E);
  assign last         = (cnt == CNT_LAST);
  assign stall_E      = vec_run & ~last;
  assign branch_taken = branch_E & (regA_E[N-1:0] == regB_E[N-1:0]) & ~flush_X;
  assign state_dbg    = state;

  // Handshake: stall_E high means the D/E register must hold its operands; the
  // op's result appears in M on the edge where stall_E was sampled low.
  always_comb begin
    state_next   = state;
    cnt_next     = cnt;
    partial_next = partial;
    regw_n       = 1'b0;
    memw_n       = 1'b0;
    regmem_n     = 1'b0;
    vect_n       = 1'b0;
    regscr_n     = '0;
    res_n        = '0;
    store_n      = '0;
    if (flush_X) begin
      state_next   = IDLE;
      cnt_next     = '0;
      partial_next = '0;
    end else if (vec_run) begin
      if (last) begin
        state_next   = IDLE;
        cnt_next     = '0;
        partial_next = '0;
        regw_n       = regw_E;
        memw_n       = memw_E;
        regmem_n     = regmem_E;
        vect_n       = 1'b1;
        regscr_n     = regScr_E;
        res_n        = merged;
        store_n      = regB_E;
      end else begin
        state_next   = BUSY;
        cnt_next     = cnt + CNT_W'(1);
        partial_next = merged;
      end
    end else if (!bubble_e) begin
      regw_n   = regw_E;
      memw_n   = memw_E;
      regmem_n = regmem_E;
      regscr_n = regScr_E;
      res_n    = {{(V-N){1'b0}}, sc_y};
      store_n  = regB_E;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= '0;
      partial  <= '0;
      regw_M   <= 1'b0;
      memw_M   <= 1'b0;
      regmem_M <= 1'b0;
      vect_M   <= 1'b0;
      regScr_M <= '0;
      res_M    <= '0;
      store_M  <= '0;
    end else begin
      state    <= state_next;
      cnt      <= cnt_next;
      partial  <= partial_next;
      regw_M   <= regw_n;
      memw_M   <= memw_n;
      regmem_M <= regmem_n;
      vect_M   <= vect_n;
      regScr_M <= regscr_n;
      res_M    <= res_n;
      store_M  <= store_n;
    end
  end

endmodule

// File: tb/tb_vexec_stage.sv
// Directed bench for vexec_stage: scalar vector table, vector multi-cycle
// sequences, flush, reset-in-flight and branch compare.
module tb_vexec_stage;
  import vexec_pkg::*;

  localparam int V = 128;
  localparam int N = 32;
  localparam int M = 4;
  localparam int L = 3;
  localparam int E = 8;
  localparam int P = 4;
  localparam int K = V / (E * P);

  localparam logic [V-N-1:0] A_HI = 96'h0123_4567_89AB_CDEF_0011_2233;
  localparam logic [V-N-1:0] B_HI = 96'hFEDC_BA98_7654_3210_A5A5_5A5A;

`ifdef VEXEC_SAT_EN
  localparam logic [N-1:0] EXP_SUB35 = 32'h0000_0000;
  localparam logic [N-1:0] EXP_OVF   = 32'hFFFF_FFFF;
  localparam logic [V-1:0] EXP_VOVF  = {16{8'hFF}};
`else
  localparam logic [N-1:0] EXP_SUB35 = 32'hFFFF_FFFE;
  localparam logic [N-1:0] EXP_OVF   = 32'h0000_0010;
  localparam logic [V-1:0] EXP_VOVF  = {16{8'h10}};
`endif

  logic         clk = 1'b0;
  logic         rst, flush_X, regw_E, memw_E, regmem_E, ALUope_E, branch_E, vect_E;
  logic [4:0]   op_code_E;
  logic [L-1:0] ALUctrl_E;
  logic [M-1:0] regScr_E;
  logic [N-1:0] inm_E;
  logic [V-1:0] regA_E, regB_E;
  logic         stall_E, branch_taken, regw_M, memw_M, regmem_M, vect_M;
  logic [M-1:0] regScr_M;
  logic [V-1:0] res_M, store_M;
  state_t       state_dbg;

  int n_cmp  = 0;
  int n_fail = 0;

  vexec_stage #(.V(V), .N(N), .M(M), .L(L), .E(E), .P(P)) dut (
    .clk(clk), .rst(rst), .flush_X(flush_X), .regw_E(regw_E), .memw_E(memw_E),
    .regmem_E(regmem_E), .ALUope_E(ALUope_E), .branch_E(branch_E), .vect_E(vect_E),
    .op_code_E(op_code_E), .ALUctrl_E(ALUctrl_E), .regScr_E(regScr_E), .inm_E(inm_E),
    .regA_E(regA_E), .regB_E(regB_E), .stall_E(stall_E), .branch_taken(branch_taken),
    .regw_M(regw_M), .memw_M(memw_M), .regmem_M(regmem_M), .vect_M(vect_M),
    .regScr_M(regScr_M), .res_M(res_M), .store_M(store_M), .state_dbg(state_dbg)
  );

  // Clock / reset
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard helpers
  task automatic check(input string name, input logic [V-1:0] act, input logic [V-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_m_zero(input string name);
    check({name, "_ctl"}, {regw_M, memw_M, regmem_M, vect_M, regScr_M}, '0);
    check({name, "_res"}, res_M, '0);
    check({name, "_store"}, store_M, '0);
    check({name, "_state"}, state_dbg, IDLE);
  endtask

  // Driver tasks
  task automatic drive_scalar(input logic regw, input logic memw, input logic [2:0] ctrl,
                              input logic [M-1:0] scr, input logic [N-1:0] a, input logic [N-1:0] b);
    regw_E = regw; memw_E = memw; regmem_E = 1'b0; ALUope_E = 1'b0; vect_E = 1'b0;
    branch_E = 1'b0; flush_X = 1'b0; ALUctrl_E = ctrl; regScr_E = scr; inm_E = '0;
    regA_E = {A_HI, a}; regB_E = {B_HI, b};
  endtask

  task automatic drive_vector(input logic [V-1:0] a, input logic [V-1:0] b, input logic [2:0] ctrl,
                              input logic aluope, input logic [N-1:0] inm);
    regw_E = 1'b1; memw_E = 1'b0; regmem_E = 1'b0; ALUope_E = aluope; vect_E = 1'b1;
    branch_E = 1'b0; flush_X = 1'b0; ALUctrl_E = ctrl; regScr_E = 4'd9; inm_E = inm;
    regA_E = a; regB_E = b;
  endtask

  task automatic run_vector(input string name, input logic [V-1:0] a, input logic [V-1:0] b,
                            input logic [2:0] ctrl, input logic aluope, input logic [N-1:0] inm,
                            input logic [V-1:0] exp);
    drive_vector(a, b, ctrl, aluope, inm);
    for (int i = 0; i < K; i++) begin
      #1;
      check($sformatf("%s_stall%0d", name, i), stall_E, (i < K - 1) ? 1'b1 : 1'b0);
      step();
      if (i < K - 1) begin
        check($sformatf("%s_bubble%0d", name, i), {regw_M, vect_M, res_M}, '0);
        check($sformatf("%s_busy%0d", name, i), state_dbg, BUSY);
      end
    end
    check({name, "_res"}, res_M, exp);
    check({name, "_ctl"}, {regw_M, memw_M, vect_M, regScr_M}, {1'b1, 1'b0, 1'b1, 4'd9});
    check({name, "_store"}, store_M, b);
    check({name, "_idle"}, state_dbg, IDLE);
  endtask

  typedef struct {
    logic         regw, memw, regmem, aluope;
    logic [2:0]   ctrl;
    logic [M-1:0] scr;
    logic [N-1:0] inm, a, b, exp;
  } vec_t;

  vec_t tbl [13];

  initial begin
    tbl[0]  = '{1'b1, 1'b0, 1'b0, 1'b1, ALU_ADD,   4'd3, 32'd7,        32'd5,          32'd99,         32'd12};
    tbl[1]  = '{1'b1, 1'b0, 1'b0, 1'b0, ALU_SUB,   4'd1, 32'd0,        32'd3,          32'd5,          EXP_SUB35};
    tbl[2]  = '{1'b1, 1'b0, 1'b0, 1'b0, ALU_AND,   4'd2, 32'd0,        32'hF0F0_1234,  32'h0FF0_FF00,  32'h00F0_1200};
    tbl[3]  = '{1'b1, 1'b0, 1'b1, 1'b0, ALU_OR,    4'd4, 32'd0,        32'hF000_0001,  32'h0000_0010,  32'hF000_0011};
    tbl[4]  = '{1'b1, 1'b0, 1'b0, 1'b0, ALU_XOR,   4'd5, 32'd0,        32'hAAAA_5555,  32'hFFFF_0000,  32'h5555_5555};
    tbl[5]  = '{1'b1, 1'b0, 1'b0, 1'b0, ALU_SHL,   4'd6, 32'd0,        32'h0000_0003,  32'h0000_000C,  32'h0000_0030};
    tbl[6]  = '{1'b1, 1'b0, 1'b0, 1'b0, ALU_MUL,   4'd7, 32'd0,        32'h0001_0003,  32'h0000_0005,  32'h0005_000F};
    tbl[7]  = '{1'b1, 1'b0, 1'b0, 1'b0, ALU_MUL,   4'd8, 32'd0,        32'h8000_0001,  32'h0000_0002,  32'h0000_0002};
    tbl[8]  = '{1'b1, 1'b0, 1'b0, 1'b1, ALU_PASSB, 4'd9, 32'h1234,     32'h0000_0077,  32'h0000_0055,  32'h0000_1234};
    tbl[9]  = '{1'b1, 1'b0, 1'b0, 1'b0, ALU_ADD,   4'd10, 32'd0,       32'hFFFF_FFF0,  32'h0000_0020,  EXP_OVF};
    tbl[10] = '{1'b0, 1'b1, 1'b0, 1'b0, ALU_ADD,   4'd11, 32'd0,       32'd1,          32'd2,          32'd3};
    tbl[11] = '{1'b0, 1'b0, 1'b0, 1'b0, ALU_ADD,   4'd12, 32'd0,       32'd1,          32'd2,          32'd3};
    tbl[12] = '{1'b1, 1'b0, 1'b0, 1'b0, ALU_SHL,   4'd13, 32'd0,       32'h0000_0001,  32'hFFFF_FFFF,  32'h0000_0080};

    // Reset with a vector request pending: stall must stay low.
    rst = 1'b1; op_code_E = '0;
    drive_vector({16{8'h01}}, {16{8'h02}}, ALU_ADD, 1'b0, '0);
    step(); step();
    check("rst_stall", stall_E, 1'b0);
    check_m_zero("rst");
    rst = 1'b0;

    // Scalar table
    for (int i = 0; i < 13; i++) begin
      logic bub;
      logic [V-1:0] exp_res, exp_store;
      bub = ~tbl[i].regw & ~tbl[i].memw;
      drive_scalar(tbl[i].regw, tbl[i].memw, tbl[i].ctrl, tbl[i].scr, tbl[i].a, tbl[i].b);
      regmem_E = tbl[i].regmem; ALUope_E = tbl[i].aluope; inm_E = tbl[i].inm;
      exp_res   = bub ? '0 : {{(V-N){1'b0}}, tbl[i].exp};
      exp_store = bub ? '0 : {B_HI, tbl[i].b};
      #1;
      check($sformatf("sc%0d_stall", i), stall_E, 1'b0);
      step();
      check($sformatf("sc%0d_res", i), res_M, exp_res);
      check($sformatf("sc%0d_store", i), store_M, exp_store);
      check($sformatf("sc%0d_ctl", i), {regw_M, memw_M, regmem_M, vect_M, regScr_M},
            bub ? 8'h00 : {tbl[i].regw, tbl[i].memw, tbl[i].regmem, 1'b0, tbl[i].scr});
    end

    // Vector ops, the last three back-to-back with no idle cycle between them
    run_vector("vadd", {16{8'h01}}, {16{8'h02}}, ALU_ADD, 1'b0, '0, {16{8'h03}});
    run_vector("vovf", {16{8'hF0}}, {16{8'h20}}, ALU_ADD, 1'b0, '0, EXP_VOVF);
    run_vector("vsubi", {16{8'h10}}, {16{8'h77}}, ALU_SUB, 1'b1, 32'hABCD_0005, {16{8'h0B}});
    run_vector("vxor", 128'h00112233_44556677_8899AABB_CCDDEEFF, {16{8'h11}}, ALU_XOR, 1'b0, '0,
               128'h11003322_55447766_9988BBAA_DDCCFFEE);
    run_vector("vmul", {16{8'h13}}, {16{8'h11}}, ALU_MUL, 1'b0, '0, {16{8'h43}});
    vect_E = 1'b0; regw_E = 1'b0;

    // Flush overrides a vector start and clears a live M stage
    drive_scalar(1'b1, 1'b0, ALU_ADD, 4'd5, 32'd1, 32'd2);
    step();
    check("fl_pre_res", res_M, {{(V-N){1'b0}}, 32'd3});
    drive_vector({16{8'h01}}, {16{8'h02}}, ALU_ADD, 1'b0, '0);
    flush_X = 1'b1;
    #1;
    check("fl_start_stall", stall_E, 1'b0);
    step();
    check_m_zero("fl_start");

    // Flush at cnt == 2
    drive_vector({16{8'h01}}, {16{8'h02}}, ALU_ADD, 1'b0, '0);
    step(); step();
    check("fl_mid_busy", state_dbg, BUSY);
    flush_X = 1'b1;
    #1;
    check("fl_mid_stall", stall_E, 1'b0);
    step();
    check_m_zero("fl_mid");
    drive_scalar(1'b1, 1'b0, ALU_ADD, 4'd2, 32'd4, 32'd4);
    step();
    check("fl_post_res", res_M, {{(V-N){1'b0}}, 32'd8});
    check("fl_post_ctl", {regw_M, regScr_M}, {1'b1, 4'd2});

    // Reset at cnt == 1, then the same vector op takes a full K cycles
    drive_vector({16{8'h01}}, {16{8'h02}}, ALU_ADD, 1'b0, '0);
    step();
    check("rb_busy", state_dbg, BUSY);
    rst = 1'b1;
    #1;
    check("rb_stall", stall_E, 1'b0);
    step();
    check_m_zero("rb");
    rst = 1'b0;
    run_vector("rb_vadd", {16{8'h01}}, {16{8'h02}}, ALU_ADD, 1'b0, '0, {16{8'h03}});

    // Branch compare (low N bits only)
    drive_scalar(1'b0, 1'b0, ALU_ADD, 4'd0, 32'd9, 32'd9);
    branch_E = 1'b1;
    #1;
    check("br_eq", branch_taken, 1'b1);
    flush_X = 1'b1;
    #1;
    check("br_flush", branch_taken, 1'b0);
    flush_X = 1'b0;
    regB_E = {B_HI, 32'd8};
    #1;
    check("br_ne", branch_taken, 1'b0);
    regB_E = {B_HI, 32'd9}; branch_E = 1'b0;
    #1;
    check("br_off", branch_taken, 1'b0);
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/vexec_stage.md
Name: vexec_stage

Overview:
- Execute stage directly downstream of the decode/execute pipeline register.
- Consumes the E-stage control bits and operands, and computes scalar ops in 1 cycle.
- Computes vector ops lane-chunk by lane-chunk over K cycles, driving stall_E back to the D/E register so its operands stay stable.
- Registers results and control into the E/M boundary, and resolves branches.

Parameters:
- V, 128, vector register width
- N, 32, scalar/immediate width
- M, 4, register index width
- L, 3, ALU control width
- E, 8, vector element width
- P, 4, elements processed per cycle; K = V/(E*P) cycles per vector op (default 4)

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- flush_X  in  1  abort E-stage op; insert bubble into M
- regw_E, memw_E, regmem_E, ALUope_E, branch_E, vect_E  in  1 each  control from D/E register
- op_code_E  in  5  opcode
- ALUctrl_E  in  L  ALU function
- regScr_E  in  M  destination register index
- inm_E  in  N  immediate
- regA_E, regB_E  in  V  operands
- stall_E  out  1  hold D/E register (and upstream)
- branch_taken  out  1  combinational; branch_E & (regA_E[N-1:0]==regB_E[N-1:0]) & ~flush_X
- regw_M, memw_M, regmem_M, vect_M  out  1 each  registered control
- regScr_M  out  M  registered destination
- res_M  out  V  registered ALU result
- store_M  out  V  registered regB_E (store data)

Behaviour:
- Reset: all outputs except branch_taken are 0; FSM = IDLE; chunk counter cnt = 0; partial result = 0.
- Operand B: ALUope_E=1 selects zero-extended inm_E, else regB_E. For vector ops the immediate is replicated into every E-bit element (low E bits).
- ALUctrl encoding (per element, modulo 2^E; scalar modulo 2^N):
  - 000 add, 001 sub, 010 and, 011 or, 100 xor
  - 101 shl by B[2:0]
  - 110 mul (low half)
  - 111 pass B
- Scalar (vect_E=0):
  - Result = N-bit op on low N bits; res_M upper V-N bits = 0.
  - Latency 1; stall_E = 0.
- Vector (vect_E=1) FSM:
  - IDLE: on vect_E & ~flush_X, compute chunk 0 (bits P*E-1:0) into partial, assert stall_E, go BUSY with cnt=1. The M outputs receive a bubble (all control 0).
  - BUSY: compute chunk cnt. While cnt<K-1: stall_E=1, bubble to M, cnt++.
  - BUSY at cnt==K-1: stall_E=0, the full result (partial plus last chunk) is registered into res_M with the instruction's control, go IDLE.
  - Total occupancy K cycles; D/E operands are held by stall_E.
- Bubble: the E stage is a bubble when regw_E, memw_E and vect_E are all 0. It passes through as zeros.
- flush_X:
  - M outputs are zeroed next edge; FSM goes to IDLE; cnt = 0; partial is discarded; stall_E is deasserted the same cycle.
  - flush_X overrides a simultaneous vector start.
- rst mid-operation behaves as flush plus full reset.
- Back-to-back vector ops: the next op starts in the cycle after the completion edge, with no extra bubble.
- Branch: evaluated on the scalar path only. branch_taken is valid only while state==IDLE.

Optional Feature:
- VEXEC_SAT_EN defined: add/sub saturate unsigned per element (add clamps to 2^E-1 or 2^N-1; sub clamps to 0), for scalar and vector.
- Undefined: add/sub wrap modulo.
- No port changes either way.

Decomposition:
- Package vexec_pkg holds:
  - ALU function localparams (ALU_ADD … ALU_PASSB)
  - FSM state enum (IDLE, BUSY)
  - function computing K from V, E, P
- Sub-module vexec_lane: one E-bit element ALU, combinational (ALUctrl, a, b -> y), honouring VEXEC_SAT_EN. It is instantiated P times for the vector path; a separate N-bit instance serves the scalar path.
- The top holds the FSM, chunk mux and E/M output registers.

Test Plan:
- Scalar add: regA=5, inm=7, ALUope=1, ALUctrl=000, vect=0, regw=1, regScr=3 -> next edge res_M=12, regw_M=1, regScr_M=3, stall_E never high.
- Vector add: regA=16×0x01, regB=16×0x02, vect=1 -> stall_E high 3 cycles, bubbles in M. Then res_M=16×0x03 at the 4th edge.
- Wrap vs. saturate: vector add of 0xF0+0x20 per element -> 0x10 without VEXEC_SAT_EN, 0xFF with it. Scalar sub 3-5 -> 0xFFFFFFFE or 0.
- Flush mid-vector: flush_X at cnt=2 -> stall_E low that cycle, M outputs all 0 next edge, FSM IDLE. Next scalar op completes normally.
- Branch: branch_E=1, regA=regB=9 -> branch_taken=1. With flush_X=1 -> 0. Unequal -> 0.
- Reset during BUSY: rst at cnt=1 -> all outputs 0, stall_E 0. Vector op re-presented afterwards takes a full K cycles.
